// File: rtl/m_pkg.sv
// Shared definitions for the x^4+x^3+1 m-sequence checker and its generator.
package m_pkg;

   // Checker FSM states: hunting for alignment, or flywheeling on prediction.
   typedef enum logic {
      SEARCH = 1'b0,
      LOCK   = 1'b1
   } state_t;

   // History taps: p = h[TAP_NEW] ^ h[TAP_OLD] realises s(n) = s(n-1) ^ s(n-4).
   localparam int TAP_NEW = 0;
   localparam int TAP_OLD = 3;

   // Number of valid bits shifted in without comparison after entering SEARCH.
   localparam int FILL_LEN = 4;

   // Reset seed of the companion generator; gives 111101011001000...
   localparam logic [3:0] SEED = 4'b1111;

endpackage

// File: rtl/m_pred.sv
// Four-bit history with next-bit prediction and mismatch detection.
// h[0] is the newest bit. In SEARCH the history follows din (self-sync);
// in LOCK it follows its own prediction so a bad bit is never fed back.
module m_pred
   import m_pkg::*;
(
   input  logic clk,
   input  logic res,
   input  logic shift,
   input  logic sel_p,
   input  logic din,
   output logic p,
   output logic m,
   output logic h_zero
);

   logic [3:0] h;
   logic       nxt;

   assign p      = h[TAP_NEW] ^ h[TAP_OLD];
   assign m      = din ^ p;
   assign h_zero = (h == 4'b0000);
   assign nxt    = sel_p ? p : din;

   // History shift register; advances only on qualified samples.
   always_ff @(posedge clk) begin
      if (!res) begin
         h <= 4'b0000;
      end else if (shift) begin
         h <= {h[2:0], nxt};
      end
   end

endmodule

// File: rtl/m_chk.sv
// Serial m-sequence checker: self-synchronises to the incoming stream,
// declares lock after LOCK_N consecutive matches, then flywheels and flags
// each mismatched bit. Loss of lock is judged once per WIN-bit window.
// lock mirrors the state register directly and serves as the FSM debug view.
module m_chk
   import m_pkg::*;
#(
   parameter int LOCK_N    = 15,
   parameter int WIN       = 15,
   parameter int UNLOCK_TH = 4,
   parameter int CNT_W     = 16
) (
   input  logic             clk,
   input  logic             res,
   input  logic             din,
   input  logic             din_vld,
   input  logic             clr,
   output logic             lock,
   output logic             err,
   output logic [CNT_W-1:0] err_cnt
);

   state_t     state;
   state_t     state_n;
   logic [2:0] fill;
   logic [7:0] match;
   logic [7:0] win;
   logic [7:0] werr;

   logic       p_unused;
   logic       m;
   logic       h_zero;

   logic       filling;
   logic       go_lock;
   logic       go_search;
   logic       win_end;
   logic       inc;
   logic [8:0] match_inc;
   logic [7:0] win_inc;
   logic [7:0] werr_inc;

   m_pred u_pred (
      .clk    (clk),
      .res    (res),
      .shift  (din_vld),
      .sel_p  (state == LOCK),
      .din    (din),
      .p      (p_unused),
      .m      (m),
      .h_zero (h_zero)
   );

   assign lock = (state == LOCK);

   // Next-state and event decode for the current valid sample.
   always_comb begin
      state_n   = state;
      filling   = 1'b0;
      go_lock   = 1'b0;
      go_search = 1'b0;
      win_end   = 1'b0;
      inc       = 1'b0;
      match_inc = {1'b0, match} + 9'd1;
      win_inc   = win + 8'd1;
      werr_inc  = werr + {7'd0, m};
      case (state)
         SEARCH: begin
            if (din_vld) begin
               if (fill < 3'(FILL_LEN)) begin
                  filling = 1'b1;
               end else if (!m && !h_zero && (match_inc == 9'(LOCK_N))) begin
                  go_lock = 1'b1;
                  state_n = LOCK;
               end
            end
         end
         LOCK: begin
            if (din_vld) begin
               inc = m;
               if (win_inc == 8'(WIN)) begin
                  win_end = 1'b1;
                  if (werr_inc >= 8'(UNLOCK_TH)) begin
                     go_search = 1'b1;
                     state_n   = SEARCH;
                  end
               end
            end
         end
         default: state_n = SEARCH;
      endcase
   end

   // State register.
   always_ff @(posedge clk) begin
      if (!res) begin
         state <= SEARCH;
      end else begin
         state <= state_n;
      end
   end

   // Fill, match-run and loss-of-lock window counters.
   always_ff @(posedge clk) begin
      if (!res) begin
         fill  <= 3'd0;
         match <= 8'd0;
         win   <= 8'd0;
         werr  <= 8'd0;
      end else if (din_vld) begin
         if (state == SEARCH) begin
            if (filling) begin
               fill <= fill + 3'd1;
            end else if (go_lock) begin
               match <= 8'd0;
               win   <= 8'd0;
               werr  <= 8'd0;
            end else if (m || h_zero) begin
               match <= 8'd0;
            end else begin
               match <= match_inc[7:0];
            end
         end else begin
            if (win_end) begin
               win  <= 8'd0;
               werr <= 8'd0;
               if (go_search) begin
                  fill  <= 3'd0;
                  match <= 8'd0;
               end
            end else begin
               win  <= win_inc;
               werr <= werr_inc;
            end
         end
      end
   end

   // Registered error pulse and saturating error counter.
   always_ff @(posedge clk) begin
      if (!res) begin
         err     <= 1'b0;
         err_cnt <= '0;
      end else begin
         err <= inc;
         if (clr) begin
            err_cnt <= inc ? CNT_W'(1) : '0;
         end else if (inc && (err_cnt != '1)) begin
            err_cnt <= err_cnt + CNT_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_m_chk.sv
// Bench for m_chk: two instances (16-bit and 4-bit error counters) share one
// stimulus stream. Each driven cycle pushes the reference model's expected
// outputs into exp_q; an independent monitor pops and compares after the edge.
module tb_m_chk;
   import m_pkg::*;

   localparam int LOCK_N    = 15;
   localparam int WIN       = 15;
   localparam int UNLOCK_TH = 4;

   // ---------------- clock / reset / DUT ----------------
   logic        clk = 1'b0;
   logic        res = 1'b0;
   logic        din = 1'b0;
   logic        din_vld = 1'b0;
   logic        clr = 1'b0;
   logic        lock_a;
   logic        err_a;
   logic [15:0] cnt_a;
   logic        lock_b;
   logic        err_b;
   logic [3:0]  cnt_b;

   always #5 clk = ~clk;

   m_chk #(.LOCK_N(LOCK_N), .WIN(WIN), .UNLOCK_TH(UNLOCK_TH), .CNT_W(16)) dut_a (
      .clk(clk), .res(res), .din(din), .din_vld(din_vld), .clr(clr),
      .lock(lock_a), .err(err_a), .err_cnt(cnt_a)
   );

   m_chk #(.LOCK_N(LOCK_N), .WIN(WIN), .UNLOCK_TH(UNLOCK_TH), .CNT_W(4)) dut_b (
      .clk(clk), .res(res), .din(din), .din_vld(din_vld), .clr(clr),
      .lock(lock_b), .err(err_b), .err_cnt(cnt_b)
   );

   // ---------------- bookkeeping ----------------
   int n_chk  = 0;
   int n_fail = 0;

   task automatic check(input string name, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   // Expressed in terms of the sequence rule: the last four bits predict the
   // next as newest ^ oldest; a run of LOCK_N correct predictions locks;
   // while locked the model trusts its own predictions.
   int hist[$];
   bit m_locked;
   int m_fill, m_run, m_win, m_werr;
   int m_cnt_a, m_cnt_b;
   bit m_err;

   task automatic model(input bit d, input bit v, input bit c, input bit r);
      int pred;
      int miss;
      bit hit;
      if (!r) begin
         m_locked = 0;
         hist = '{0, 0, 0, 0};
         m_fill = 0; m_run = 0; m_win = 0; m_werr = 0;
         m_err = 0; m_cnt_a = 0; m_cnt_b = 0;
         return;
      end
      hit = 0;
      m_err = 0;
      if (v) begin
         pred = hist[0] ^ hist[3];
         miss = int'(d) ^ pred;
         if (!m_locked) begin
            if (m_fill < 4) m_fill++;
            else if (miss != 0 || hist.sum() == 0) m_run = 0;
            else begin
               m_run++;
               if (m_run == LOCK_N) begin
                  m_locked = 1; m_run = 0; m_win = 0; m_werr = 0;
               end
            end
            hist.push_front(int'(d));
         end else begin
            hit = (miss != 0);
            m_err = hit;
            m_win++;
            m_werr += miss;
            hist.push_front(pred);
            if (m_win == WIN) begin
               if (m_werr >= UNLOCK_TH) begin
                  m_locked = 0; m_fill = 0; m_run = 0;
               end
               m_win = 0; m_werr = 0;
            end
         end
         void'(hist.pop_back());
      end
      if (c) begin
         m_cnt_a = int'(hit);
         m_cnt_b = int'(hit);
      end else if (hit) begin
         if (m_cnt_a < 65535) m_cnt_a++;
         if (m_cnt_b < 15) m_cnt_b++;
      end
   endtask

   // ---------------- scoreboard ----------------
   logic [21:0] exp_q[$];
   logic [21:0] mon_e;

   // Monitor: compare every DUT output against the oldest expectation.
   always begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
         mon_e = exp_q.pop_front();
         check("lock_a", int'(lock_a), int'(mon_e[21]));
         check("err_a",  int'(err_a),  int'(mon_e[20]));
         check("cnt_a",  int'(cnt_a),  int'(mon_e[19:4]));
         check("lock_b", int'(lock_b), int'(mon_e[21]));
         check("err_b",  int'(err_b),  int'(mon_e[20]));
         check("cnt_b",  int'(cnt_b),  int'(mon_e[3:0]));
      end
   end

   // ---------------- driver ----------------
   int seq[15];
   int gi;

   task automatic step(input bit d, input bit v, input bit c, input bit r);
      @(negedge clk);
      din = d; din_vld = v; clr = c; res = r;
      model(d, v, c, r);
      exp_q.push_back({m_locked, m_err, 16'(m_cnt_a), 4'(m_cnt_b)});
      @(posedge clk);
      #2;
   endtask

   // One generator-driven cycle; flip corrupts the transmitted bit.
   task automatic gen(input bit flip, input bit v, input bit c);
      bit d;
      if (v) begin
         d = bit'(seq[gi]) ^ flip;
         gi = (gi + 1) % 15;
      end else begin
         d = bit'($urandom_range(0, 1));
      end
      step(d, v, c, 1'b1);
   endtask

   // Reset with clr and din_vld asserted to show reset dominates; the
   // generator restarts on the same edge the checker is released.
   task automatic do_reset();
      step(1'b1, 1'b1, 1'b1, 1'b0);
      step(1'b0, 1'b0, 1'b0, 1'b0);
      gi = 0;
   endtask

   initial begin
      int first, pulses, nv, seen;
      for (int i = 0; i < 4; i++) seq[i] = int'(SEED[3-i]);
      for (int i = 4; i < 15; i++) seq[i] = seq[i-1] ^ seq[i-4];
      gi = 0;
      do_reset();

      // 1: clean stream from reset
      first = -1;
      for (int i = 1; i <= 600; i++) begin
         gen(1'b0, 1'b1, 1'b0);
         if (first < 0 && lock_a) first = i;
      end
      check("t1_lock_at", first, 19);
      check("t1_cnt", int'(cnt_a), 0);

      // 2: one corrupted bit while locked
      pulses = 0;
      gen(1'b1, 1'b1, 1'b0);
      pulses += int'(err_a);
      for (int i = 0; i < 40; i++) begin
         gen(1'b0, 1'b1, 1'b0);
         pulses += int'(err_a);
      end
      check("t2_pulses", pulses, 1);
      check("t2_cnt", int'(cnt_a), 1);
      check("t2_lock", int'(lock_a), 1);

      // 3: four errors inside one window force loss of lock
      gen(1'b0, 1'b1, 1'b1);
      for (int i = 0; i < 20 && m_win != 0; i++) gen(1'b0, 1'b1, 1'b0);
      pulses = 0;
      for (int j = 0; j < WIN; j++) begin
         gen((j % 3 == 0) && (j < 10), 1'b1, 1'b0);
         pulses += int'(err_a);
      end
      check("t3_pulses", pulses, 4);
      check("t3_lock_fell", int'(lock_a), 0);
      check("t3_cnt", int'(cnt_a), 4);
      first = -1;
      for (int i = 1; i <= 40; i++) begin
         gen(1'b0, 1'b1, 1'b0);
         if (first < 0 && lock_a) first = i;
      end
      check("t3_relock_at", first, 19);
      check("t3_cnt_held", int'(cnt_a), 4);

      // 4: stuck-at-0 then stuck-at-1 never locks
      do_reset();
      seen = 0;
      for (int i = 0; i < 400; i++) begin
         step(bit'(i >= 200), 1'b1, 1'b0, 1'b1);
         seen += int'(lock_a) + int'(err_a);
      end
      check("t4_lock_or_err", seen, 0);

      // 5: half-rate valid on a clean stream
      do_reset();
      first = -1;
      nv = 0;
      for (int i = 0; i < 80; i++) begin
         gen(1'b0, bit'(i % 2 == 0), 1'b0);
         if (i % 2 == 0) nv++;
         if (first < 0 && lock_a) first = nv;
      end
      check("t5_lock_at_valid", first, 19);
      for (int i = 0; i < 30; i++) gen(1'b0, 1'b1, 1'b0);

      // 6: saturation, clear and mid-lock reset
      gen(1'b0, 1'b1, 1'b1);
      for (int e = 0; e < 20; e++) begin
         gen(1'b1, 1'b1, 1'b0);
         for (int k = 0; k < 7; k++) gen(1'b0, 1'b1, 1'b0);
      end
      check("t6_cnt_b_sat", int'(cnt_b), 15);
      check("t6_cnt_a", int'(cnt_a), 20);
      check("t6_lock_b", int'(lock_b), 1);
      gen(1'b1, 1'b1, 1'b1);
      check("t6_clr_inc_a", int'(cnt_a), 1);
      check("t6_clr_inc_b", int'(cnt_b), 1);
      gen(1'b0, 1'b1, 1'b1);
      check("t6_clr_cnt", int'(cnt_b), 0);
      check("t6_clr_lock", int'(lock_b), 1);
      step(1'b1, 1'b1, 1'b1, 1'b0);
      check("t6_res_lock", int'(lock_b), 0);
      check("t6_res_cnt", int'(cnt_a), 0);
      gi = 0;

      // 7: random valid pattern, sparse errors, then an error burst
      for (int i = 0; i < 300; i++)
         gen(bit'($urandom_range(0, 19) == 0), bit'($urandom_range(0, 3) != 0),
             bit'($urandom_range(0, 49) == 0));
      for (int i = 0; i < 100; i++)
         gen(bit'($urandom_range(0, 2) == 0), 1'b1, 1'b0);
      for (int i = 0; i < 100; i++)
         gen(1'b0, bit'($urandom_range(0, 1)), 1'b0);

      @(negedge clk);
      @(negedge clk);
      check("queue_drained", exp_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
